// File: rtl/ab_seq_tx.sv
// ab_seq_tx: buffers up to DEPTH two-bit (a,b) symbols and replays them
// one per clock, one-shot or looping, with abort.
module ab_seq_tx #(
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          wr_en,
    input  logic [1:0]    wr_sym,
    input  logic          clear,
    input  logic          start,
    input  logic          loop,
    input  logic          stop,
    output logic          a,
    output logic          b,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic          full,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            a_q, a_d;
    logic            b_q, b_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            full_q, full_d;
    logic [1:0]      mem_q [DEPTH];
    logic            mem_we;
    logic [PW-1:0]   mem_widx;
    logic            at_last;
    logic [PW-1:0]   rd_next;

    assign at_last = (CW'(rd_ptr_q) == (count_q - CW'(1)));
    assign rd_next = rd_ptr_q + PW'(1);

    // Next-state, buffer bookkeeping and registered output values.
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        a_d      = 1'b0;
        b_d      = 1'b0;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        mem_we   = 1'b0;
        mem_widx = PW'(count_q);
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    count_d = '0;
                end else if (start && count_q != '0) begin
                    state_d    = SEND;
                    rd_ptr_d   = '0;
                    {a_d, b_d} = mem_q[0];
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                end else if (wr_en && !full_q) begin
                    mem_we  = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            SEND: begin
                if (stop) begin
                    state_d  = IDLE;
                    rd_ptr_d = '0;
                end else if (at_last && !loop) begin
                    state_d  = DONE;
                    rd_ptr_d = '0;
                    done_d   = 1'b1;
                end else if (at_last) begin
                    rd_ptr_d   = '0;
                    {a_d, b_d} = mem_q[0];
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    rd_ptr_d   = rd_next;
                    {a_d, b_d} = mem_q[rd_next];
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                rd_ptr_d = '0;
            end
        endcase
        full_d = (count_d == CW'(DEPTH));
    end

    // Control state and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            count_q  <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            a_q      <= a_d;
            b_q      <= b_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            full_q   <= full_d;
        end
    end

    // Symbol storage survives reset; only count decides what is live.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_widx] <= wr_sym;
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign full  = full_q;
    assign count = count_q;

endmodule
